// File: rtl/ili9341_spi_display.sv
// ILI9341 write-only 4-wire SPI streamer: power-up init, full-panel address
// window, then one RGB565 pixel per 32-cycle slot fed through data_clk.
module ili9341_spi_display #(
  parameter int PIXEL_SIZE   = 16,
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 240,
  parameter int DELAY_CYCLES = 4_000_000
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  frame_done,
  input  logic [PIXEL_SIZE-1:0] input_data,
  output logic                  spi_mosi,
  output logic                  spi_sck,
  output logic                  spi_cs,
  output logic                  spi_dc,
  output logic                  data_clk
);
  typedef enum logic [2:0] {PWR_WAIT, INIT, INIT_DLY, WINDOW, STREAM, FRAME_WAIT} state_t;

  localparam logic [31:0] DLY_END = 32'(DELAY_CYCLES - 1);
  localparam logic [7:0]  COL_END = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_END = 8'(HEIGHT - 1);

  state_t      state_r, state_n;
  logic [3:0]  idx_r, idx_n;
  logic [31:0] dly_r, dly_n;
  logic        hi_r, hi_n;
  logic [4:0]  phase_r;
  logic [7:0]  pend_r;
  logic [7:0]  byte_r;
  logic        dcb_r, on_r, act_r;
  logic        bnd_s, send_s, hold_s, dc_s;
  logic [7:0]  byte_s;
  logic [3:0]  k_n_s;

  // {dc, byte}; index 7 is an idle slot that separates init from the window
  function automatic logic [8:0] init_rom(input logic [3:0] i);
    case (i)
      4'd0:    init_rom = {1'b0, 8'h01};
      4'd1:    init_rom = {1'b0, 8'h11};
      4'd2:    init_rom = {1'b0, 8'h3A};
      4'd3:    init_rom = {1'b1, 8'h55};
      4'd4:    init_rom = {1'b0, 8'h36};
      4'd5:    init_rom = {1'b1, 8'h48};
      4'd6:    init_rom = {1'b0, 8'h29};
      default: init_rom = {1'b0, 8'h00};
    endcase
  endfunction

  function automatic logic [8:0] win_rom(input logic [3:0] i);
    case (i)
      4'd0:    win_rom = {1'b0, 8'h2A};
      4'd4:    win_rom = {1'b1, COL_END};
      4'd5:    win_rom = {1'b0, 8'h2B};
      4'd9:    win_rom = {1'b1, ROW_END};
      4'd10:   win_rom = {1'b0, 8'h2C};
      default: win_rom = {1'b1, 8'h00};
    endcase
  endfunction

  assign bnd_s = (phase_r[3:0] == 4'hF);
  assign k_n_s = phase_r[3:0] + 4'd1;

  // State register, slot phase and pixel pending register
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_r <= PWR_WAIT;
      idx_r   <= 4'd0;
      dly_r   <= 32'd0;
      hi_r    <= 1'b0;
      phase_r <= 5'd0;
      pend_r  <= 8'd0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      dly_r   <= dly_n;
      hi_r    <= hi_n;
      phase_r <= phase_r + 5'd1;
      if (phase_r == 5'd31) pend_r <= input_data[7:0];
      else                  pend_r <= pend_r;
    end
  end

  // Next state and the byte (if any) to launch at this byte boundary
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    dly_n   = dly_r;
    hi_n    = hi_r;
    send_s  = 1'b0;
    hold_s  = 1'b0;
    dc_s    = 1'b0;
    byte_s  = 8'h00;
    case (state_r)
      PWR_WAIT: begin
        if (dly_r == DLY_END) begin
          dly_n = 32'd0; idx_n = 4'd0; state_n = INIT;
        end else begin
          dly_n = dly_r + 32'd1;
        end
      end
      INIT_DLY: begin
        if (dly_r == DLY_END) begin
          dly_n = 32'd0; state_n = INIT;
        end else begin
          dly_n = dly_r + 32'd1;
        end
      end
      INIT: begin
        if (!bnd_s) begin
          idx_n = idx_r;
        end else if (idx_r == 4'd7) begin
          idx_n = 4'd0; state_n = WINDOW;
        end else begin
          send_s = 1'b1;
          {dc_s, byte_s} = init_rom(idx_r);
          idx_n = idx_r + 4'd1;
          if (idx_r <= 4'd1) state_n = INIT_DLY;
          else               state_n = INIT;
        end
      end
      WINDOW: begin
        if (bnd_s) begin
          send_s = 1'b1;
          {dc_s, byte_s} = win_rom(idx_r);
          if (idx_r == 4'd10) begin
            idx_n = 4'd0; hi_n = 1'b0; state_n = STREAM;
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else begin
          idx_n = idx_r;
        end
      end
      STREAM: begin
        if (phase_r == 5'd31) begin
          if (frame_done) begin
            hi_n = 1'b0; state_n = FRAME_WAIT;
          end else begin
            send_s = 1'b1; dc_s = 1'b1; hi_n = 1'b1;
            byte_s = input_data[PIXEL_SIZE-1 -: 8];
          end
        end else if (phase_r == 5'd15) begin
          // cs stays low while waiting for the first slot to align to phase 0
          if (hi_r) begin
            send_s = 1'b1; dc_s = 1'b1; hi_n = 1'b0; byte_s = pend_r;
          end else begin
            hold_s = 1'b1;
          end
        end else begin
          hi_n = hi_r;
        end
      end
      FRAME_WAIT: begin
        if ((phase_r == 5'd31) && !frame_done) begin
          send_s = 1'b1;
          {dc_s, byte_s} = win_rom(4'd0);
          idx_n = 4'd1; state_n = WINDOW;
        end else begin
          idx_n = idx_r;
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // Registered SPI pins: bit (7 - k/2) on MOSI, SCK high on odd k
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      byte_r   <= 8'd0;
      dcb_r    <= 1'b0;
      on_r     <= 1'b0;
      act_r    <= 1'b0;
      spi_mosi <= 1'b0;
      spi_sck  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_dc   <= 1'b0;
      data_clk <= 1'b0;
    end else begin
      data_clk <= ~phase_r[4];
      if (bnd_s) begin
        byte_r   <= byte_s;
        dcb_r    <= dc_s;
        on_r     <= send_s;
        act_r    <= send_s | hold_s;
        spi_mosi <= send_s & byte_s[7];
        spi_sck  <= 1'b0;
        spi_cs   <= ~(send_s | hold_s);
        spi_dc   <= send_s & dc_s;
      end else begin
        spi_mosi <= on_r & byte_r[3'd7 - k_n_s[3:1]];
        spi_sck  <= on_r & k_n_s[0];
        spi_cs   <= ~act_r;
        spi_dc   <= on_r & dcb_r;
      end
    end
  end
endmodule

// File: tb/tb_ili9341_spi_display.sv
// Scoreboard bench: decodes SPI bytes on SCK rises and compares {dc, byte}
// against the sequence queued when the stimulus is applied.
module tb_ili9341_spi_display;
  logic        clk_out = 1'b0;
  logic        rst;
  logic        frame_done;
  logic [15:0] input_data;
  logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

  always #5 clk_out = ~clk_out;

  ili9341_spi_display #(
    .PIXEL_SIZE(16), .WIDTH(240), .HEIGHT(240), .DELAY_CYCLES(20)
  ) dut (
    .clk_out(clk_out), .rst(rst), .frame_done(frame_done), .input_data(input_data),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_dc(spi_dc),
    .data_clk(data_clk)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int bit_n = 0;
  int seen_2c = 0;
  logic [6:0] sh = 7'd0;
  logic dc0 = 1'b0;
  logic [7:0] dec_b;
  logic [8:0] dec_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_init();
    logic [8:0] s [7] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic push_window();
    logic [8:0] s [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                           9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};
    foreach (s[i]) exp_q.push_back(s[i]);
  endtask

  task automatic push_pix(input logic [15:0] w);
    exp_q.push_back({1'b1, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic wait_dclk_rise();
    logic prev;
    int n;
    prev = data_clk;
    n = 0;
    forever begin
      tick();
      n++;
      if (data_clk && !prev) break;
      prev = data_clk;
      if (n >= 100) begin
        check_eq("dclk_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic wait_2c(input int target);
    int n;
    n = 0;
    while (seen_2c < target && n < 4000) begin
      tick();
      n++;
    end
    if (seen_2c < target) check_eq("wait_2c_timeout", 32'(seen_2c), 32'(target));
  endtask

  always @(posedge clk_out) cyc <= cyc + 1;

  // SPI byte decoder: one bit per SCK-high cycle, sampled mid-cycle
  always @(negedge clk_out) begin
    if (!rst) begin
      bit_n <= 0;
    end else if (spi_sck) begin
      check_eq("cs_bit", {31'd0, spi_cs}, 32'd0);
      if (bit_n == 0) dc0 <= spi_dc;
      if (bit_n == 7) begin
        dec_b = {sh, spi_mosi};
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", {23'd0, spi_dc, dec_b}, 32'hFFFF_FFFF);
        end else begin
          dec_e = exp_q.pop_front();
          check_eq("byte", {22'd0, dc0, spi_dc, dec_b}, {22'd0, dec_e[8], dec_e[8], dec_e[7:0]});
        end
        if (dec_b == 8'h2C && !spi_dc) seen_2c <= seen_2c + 1;
        bit_n <= 0;
      end else begin
        sh <= {sh[5:0], spi_mosi};
        bit_n <= bit_n + 1;
      end
    end
  end

  initial begin
    int t0, lows, rises, n;
    logic prev;
    rst = 1'b0;
    frame_done = 1'b0;
    input_data = 16'hF800;
    repeat (5) tick();
    check_eq("rst_cs",   {31'd0, spi_cs},   32'd1);
    check_eq("rst_sck",  {31'd0, spi_sck},  32'd0);
    check_eq("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check_eq("rst_dc",   {31'd0, spi_dc},   32'd0);
    check_eq("rst_dclk", {31'd0, data_clk}, 32'd0);
    rst = 1'b1;
    push_init();
    push_window();
    push_pix(16'hF800);

    wait_dclk_rise();
    t0 = cyc;
    wait_dclk_rise();
    check_eq("dclk_period", 32'(cyc - t0), 32'd32);

    // first pixel is the word held before streaming; then new words per strobe
    wait_2c(1);
    wait_dclk_rise(); input_data = 16'h07E0; push_pix(16'h07E0);
    wait_dclk_rise(); input_data = 16'h001F; push_pix(16'h001F);
    wait_dclk_rise(); frame_done = 1'b1; input_data = 16'hFFFF;

    repeat (32) tick();
    lows = 0;
    rises = 0;
    prev = data_clk;
    repeat (96) begin
      tick();
      if (!spi_cs) lows++;
      if (data_clk && !prev) rises++;
      prev = data_clk;
    end
    check_eq("pause_cs_low", 32'(lows), 32'd0);
    check_eq("pause_dclk",   32'(rises), 32'd3);
    check_eq("pause_q",      32'(exp_q.size()), 32'd0);

    wait_dclk_rise();
    frame_done = 1'b0;
    input_data = 16'hF800;
    push_window();
    push_pix(16'hF800);
    wait_2c(2);
    wait_dclk_rise(); input_data = 16'h07E0; push_pix(16'h07E0);
    wait_dclk_rise(); input_data = 16'hA5C3; push_pix(16'hA5C3);
    wait_dclk_rise();
    repeat (5) tick();
    check_eq("pre_rst_q", 32'(exp_q.size()), 32'd2);

    rst = 1'b0;
    frame_done = 1'b1;
    tick();
    check_eq("mid_rst_cs",   {31'd0, spi_cs},   32'd1);
    check_eq("mid_rst_sck",  {31'd0, spi_sck},  32'd0);
    check_eq("mid_rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check_eq("mid_rst_dc",   {31'd0, spi_dc},   32'd0);
    check_eq("mid_rst_dclk", {31'd0, data_clk}, 32'd0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    push_init();
    push_window();

    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    check_eq("final_q", 32'(exp_q.size()), 32'd0);
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
